conv_frame_ctrl: RTL and testbench

- Sequencing controller for the streaming convolution datapath (conv).
- Owns the frame-level schedule for AXI-Stream video: latches frame geometry at start-of-frame and tracks input and output pixel positions.
- Gates the input and output handshakes across the kernel pipeline lag, and drains the pipeline after the last input pixel.
- Emits per-beat border masks so the datapath can apply its extension strategy (ZERO_PAD/REPLICATE) without knowing the frame geometry.

---
 rtl/conv_frame_ctrl_if.sv | 26 ++
 rtl/conv_frame_ctrl.sv | 103 ++++++++++
 tb/tb_conv_frame_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if: geometry, stream handshake, border masks and status of the convolution frame controller
interface conv_frame_ctrl_if #(
    parameter int KERNEL_DIAMETER_N = 5,
    parameter int IMG_W_MAX = 1920,
    parameter int IMG_H_MAX = 1080
);
    localparam int R = (KERNEL_DIAMETER_N - 1) / 2;
    localparam int X_W = $clog2(IMG_W_MAX + 1);
    localparam int Y_W = $clog2(IMG_H_MAX + 1);
    logic [X_W-1:0] cfg_width;
    logic [Y_W-1:0] cfg_height;
    logic s_tvalid, s_tuser, s_tlast, s_tready;
    logic m_tready, adv, pad, m_tvalid, m_tuser, m_tlast;
    logic [R-1:0] top_mask, bot_mask, lft_mask, rgt_mask;
    logic busy, err_cfg, err_sync;
    modport master(
        output cfg_width, cfg_height, s_tvalid, s_tuser, s_tlast, m_tready,
        input s_tready, adv, pad, m_tvalid, m_tuser, m_tlast,
        input top_mask, bot_mask, lft_mask, rgt_mask, busy, err_cfg, err_sync
    );
    modport slave(
        input cfg_width, cfg_height, s_tvalid, s_tuser, s_tlast, m_tready,
        output s_tready, adv, pad, m_tvalid, m_tuser, m_tlast,
        output top_mask, bot_mask, lft_mask, rgt_mask, busy, err_cfg, err_sync
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame scheduler for the streaming convolution datapath (fill, paired run, padded drain, border masks)
module conv_frame_ctrl #(
    parameter int KERNEL_DIAMETER_N = 5,
    parameter int IMG_W_MAX = 1920,
    parameter int IMG_H_MAX = 1080
) (
    input logic clk,
    input logic arst,
    conv_frame_ctrl_if.slave bus
);
    localparam int R = (KERNEL_DIAMETER_N - 1) / 2;
    localparam int X_W = $clog2(IMG_W_MAX + 1);
    localparam int Y_W = $clog2(IMG_H_MAX + 1);
    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
    state_t state;
    logic [X_W-1:0] w, ix, ox;
    logic [Y_W-1:0] h, iy, oy;
    logic legal, ready, valid, advance, in_acc, out_hs, sof, ix_last, ox_last;
    logic [R-1:0] top, bot, lft, rgt;
    assign legal = 32'(bus.cfg_width) >= KERNEL_DIAMETER_N && 32'(bus.cfg_width) <= IMG_W_MAX &&
                   32'(bus.cfg_height) >= KERNEL_DIAMETER_N && 32'(bus.cfg_height) <= IMG_H_MAX;
    assign ready = state == IDLE || state == FILL || (state == RUN && bus.m_tready);
    assign valid = state == RUN ? bus.s_tvalid : state == DRAIN;
    assign in_acc = bus.s_tvalid && ready;
    assign out_hs = valid && bus.m_tready;
    assign sof = state == IDLE && in_acc && bus.s_tuser && legal;
    assign advance = sof || (state == FILL && bus.s_tvalid) || (state == RUN && out_hs) || (state == DRAIN && bus.m_tready);
    assign ix_last = ix == w - X_W'(1);
    assign ox_last = ox == w - X_W'(1);
    // everything is forced low while reset is held, even the IDLE-state ready
    assign bus.s_tready = !arst && ready;
    assign bus.adv = !arst && advance;
    assign bus.pad = !arst && state == DRAIN;
    assign bus.m_tvalid = !arst && valid;
    assign bus.m_tuser = !arst && valid && ox == '0 && oy == '0;
    assign bus.m_tlast = !arst && valid && ox_last;
    assign bus.busy = !arst && state != IDLE;
    assign bus.err_cfg = !arst && state == IDLE && in_acc && bus.s_tuser && !legal;
    assign bus.err_sync = !arst && (state == FILL || state == RUN) && in_acc && (bus.s_tlast != ix_last || bus.s_tuser);
    assign bus.top_mask = arst ? '0 : top;
    assign bus.bot_mask = arst ? '0 : bot;
    assign bus.lft_mask = arst ? '0 : lft;
    assign bus.rgt_mask = arst ? '0 : rgt;
    // border masks decoded from the output position of the window centre
    always_comb begin
        top = '0;
        bot = '0;
        lft = '0;
        rgt = '0;
        for (int i = 0; i < R; i++) begin
            top[i] = 32'(oy) < i + 1;
            bot[i] = 32'(oy) + i + 1 >= 32'(h);
            lft[i] = 32'(ox) < i + 1;
            rgt[i] = 32'(ox) + i + 1 >= 32'(w);
        end
    end
    // frame schedule and position counters; the lag of R*W+R beats ends at input (x=R-1, y=R)
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            w <= '0;
            h <= '0;
            ix <= '0;
            iy <= '0;
            ox <= '0;
            oy <= '0;
        end else begin
            case (state)
                IDLE: if (sof) begin
                    state <= FILL;
                    w <= bus.cfg_width;
                    h <= bus.cfg_height;
                    ix <= X_W'(1);
                    iy <= '0;
                    ox <= '0;
                    oy <= '0;
                end
                FILL, RUN: begin
                    if (in_acc) begin
                        ix <= ix_last ? '0 : ix + X_W'(1);
                        iy <= iy + Y_W'(ix_last);
                    end
                    if (out_hs) begin
                        ox <= ox_last ? '0 : ox + X_W'(1);
                        oy <= oy + Y_W'(ox_last);
                    end
                    if (state == FILL && in_acc && 32'(ix) == R - 1 && 32'(iy) == R) state <= RUN;
                    if (state == RUN && in_acc && ix_last && iy == h - Y_W'(1)) state <= DRAIN;
                end
                DRAIN: if (out_hs) begin
                    if (ox_last && oy == h - Y_W'(1)) begin
                        state <= IDLE;
                        ox <= '0;
                        oy <= '0;
                    end else begin
                        ox <= ox_last ? '0 : ox + X_W'(1);
                        oy <= oy + Y_W'(ox_last);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: randomized frames checked against a beat-count model of the frame schedule
module tb_conv_frame_ctrl;
    localparam int K = 3;
    localparam int WM = 16;
    localparam int HM = 16;
    localparam int R = (K - 1) / 2;
    localparam int XW = $clog2(WM + 1);
    localparam int YW = $clog2(HM + 1);
    logic clk = 0;
    logic arst = 1;
    int tests = 0;
    int fails = 0;
    conv_frame_ctrl_if #(.KERNEL_DIAMETER_N(K), .IMG_W_MAX(WM), .IMG_H_MAX(HM)) bus();
    conv_frame_ctrl #(.KERNEL_DIAMETER_N(K), .IMG_W_MAX(WM), .IMG_H_MAX(HM)) dut(.clk(clk), .arst(arst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.s_tready, bus.adv, bus.pad, bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.busy,
                    bus.err_cfg, bus.err_sync, bus.top_mask, bus.bot_mask, bus.lft_mask, bus.rgt_mask});
    endfunction

    task automatic run_frame(input int w, input int h, input int pv, input int pr, input int err_idx, input int abort_after);
        int l, n, in_cnt, out_cnt, cyc, ox, oy;
        bit fill, run, drain, acc, hs;
        logic [R-1:0] et, eb, el, er;
        l = R * w + R;
        n = w * h;
        in_cnt = 0;
        out_cnt = 0;
        cyc = 0;
        while (out_cnt < n && cyc < 30 * n + 50 && (abort_after == 0 || cyc < abort_after)) begin
            @(posedge clk);
            #1;
            bus.s_tvalid = (in_cnt < n) && ($urandom_range(0, 99) >= pv);
            bus.s_tuser = in_cnt == 0;
            bus.s_tlast = ((in_cnt % w) == w - 1) ^ (in_cnt == err_idx);
            bus.m_tready = $urandom_range(0, 99) >= pr;
            bus.cfg_width = in_cnt == 0 ? XW'(w) : XW'($urandom_range(0, 31));
            bus.cfg_height = in_cnt == 0 ? YW'(h) : YW'($urandom_range(0, 31));
            @(negedge clk);
            cyc++;
            fill = in_cnt < l;
            drain = in_cnt == n;
            run = !fill && !drain;
            acc = bus.s_tvalid && bus.s_tready;
            hs = bus.m_tvalid && bus.m_tready;
            chk("s_tready", bus.s_tready, fill ? 1 : run ? bus.m_tready : 0);
            chk("m_tvalid", bus.m_tvalid, run ? bus.s_tvalid : drain);
            chk("adv", bus.adv, fill ? bus.s_tvalid : run ? (bus.s_tvalid && bus.m_tready) : bus.m_tready);
            chk("pad", bus.pad, drain);
            chk("busy", bus.busy, in_cnt > 0);
            chk("err_cfg", bus.err_cfg, 0);
            chk("err_sync", bus.err_sync, acc && in_cnt > 0 && (bus.s_tlast != ((in_cnt % w) == w - 1)));
            if (hs) begin
                ox = out_cnt % w;
                oy = out_cnt / w;
                for (int i = 0; i < R; i++) begin
                    et[i] = oy < i + 1;
                    eb[i] = oy + i + 1 > h - 1;
                    el[i] = ox < i + 1;
                    er[i] = ox + i + 1 > w - 1;
                end
                chk("m_tuser", bus.m_tuser, out_cnt == 0);
                chk("m_tlast", bus.m_tlast, ox == w - 1);
                chk("pad_tail", bus.pad, out_cnt >= n - l);
                chk("masks", {bus.top_mask, bus.bot_mask, bus.lft_mask, bus.rgt_mask}, {et, eb, el, er});
                if (run) chk("pairing", acc, 1);
            end
            if (acc) in_cnt++;
            if (hs) out_cnt++;
        end
        if (abort_after == 0) chk("out_count", out_cnt, n);
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        bus.s_tvalid = 0;
        bus.s_tuser = 0;
        bus.s_tlast = 0;
        bus.m_tready = 1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_ready", bus.s_tready, 1);
        chk("idle_valid", bus.m_tvalid, 0);
    endtask

    task automatic bad_sof(input int w, input int h);
        @(posedge clk);
        #1;
        bus.cfg_width = XW'(w);
        bus.cfg_height = YW'(h);
        bus.s_tvalid = 1;
        bus.s_tuser = 1;
        bus.s_tlast = 0;
        bus.m_tready = 1;
        @(negedge clk);
        chk("bad_err_cfg", bus.err_cfg, 1);
        chk("bad_adv", bus.adv, 0);
        chk("bad_ready", bus.s_tready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.s_tuser = 0;
            bus.s_tlast = i == 2;
            bus.cfg_width = XW'(4);
            bus.cfg_height = YW'(3);
            @(negedge clk);
            chk("discard_err_cfg", bus.err_cfg, 0);
            chk("discard_adv", bus.adv, 0);
            chk("discard_valid", bus.m_tvalid, 0);
            chk("discard_busy", bus.busy, 0);
            chk("discard_ready", bus.s_tready, 1);
        end
    endtask

    initial begin
        bus.cfg_width = XW'(4);
        bus.cfg_height = YW'(3);
        bus.s_tvalid = 1;
        bus.s_tuser = 1;
        bus.s_tlast = 0;
        bus.m_tready = 1;
        #2;
        chk("reset_outputs", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        bus.s_tvalid = 0;
        arst = 0;
        @(negedge clk);
        chk("post_reset_ready", bus.s_tready, 1);
        chk("post_reset_busy", bus.busy, 0);
        run_frame(4, 3, 0, 0, -1, 0);
        idle_check();
        run_frame(4, 3, 40, 40, -1, 0);
        idle_check();
        bad_sof(2, 3);
        bad_sof(17, 5);
        bad_sof(5, 2);
        run_frame(4, 3, 0, 0, 2, 0);
        idle_check();
        run_frame(5, 4, 20, 20, -1, 0);
        run_frame(3, 3, 0, 0, -1, 0);
        idle_check();
        for (int f = 0; f < 4; f++) begin
            run_frame(int'($urandom_range(3, 8)), int'($urandom_range(3, 6)), 30, 30, -1, 0);
            idle_check();
        end
        run_frame(4, 3, 0, 0, -1, 8);
        @(posedge clk);
        #1;
        bus.s_tvalid = 1;
        bus.s_tuser = 0;
        bus.m_tready = 1;
        arst = 1;
        #1;
        chk("midrun_reset_outputs", outs(), 0);
        @(posedge clk);
        #1;
        bus.s_tvalid = 0;
        arst = 0;
        @(negedge clk);
        chk("release_ready", bus.s_tready, 1);
        chk("release_busy", bus.busy, 0);
        run_frame(4, 3, 0, 0, -1, 0);
        idle_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
